instr_exec_unit: RTL and testbench

Downstream consumer of instr_register. On a start pulse it walks read_pointer over a programmed window of register slots and samples each instruction_word. It executes the opcode on operand_a/operand_b and presents one signed result per instruction on a valid/ready output port. It sits between the instruction register and the result checker/scoreboard in the lab top-level.

---
 rtl/instr_register_pkg.sv | 42 ++++
 rtl/instr_exec_unit_if.sv | 26 ++
 rtl/instr_alu.sv | 42 ++++
 rtl/instr_exec_unit.sv | 121 ++++++++++++
 tb/tb_instr_exec_unit.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and the execution unit that
// consumes it: opcodes, operands, slot addresses, instruction words,
// result type and the execution FSM state encoding.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef logic signed [63:0] result_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    HOLD   = 3'd3,
    FINISH = 3'd4
  } exec_state_t;

  localparam int MAX_COUNT = 32;

  // Error flag bits carried alongside each result.
  localparam logic [1:0] ERR_DIV0    = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

endpackage

// File: rtl/instr_exec_unit_if.sv
// Result port of the execution unit: valid/ready handshake plus the
// result payload (slot, opcode, signed value, error flags).
interface instr_exec_unit_if
  import instr_register_pkg::*;
#(
  parameter int RES_WIDTH = 64
);
  logic                        res_valid;
  logic                        res_ready;
  address_t                    res_addr;
  opcode_t                     res_opcode;
  logic signed [RES_WIDTH-1:0] result;
  logic [1:0]                  res_err;

  // Producer side: the execution unit.
  modport master (
    output res_valid, res_addr, res_opcode, result, res_err,
    input  res_ready
  );

  // Consumer side: checker / scoreboard.
  modport slave (
    input  res_valid, res_addr, res_opcode, result, res_err,
    output res_ready
  );
endinterface

// File: rtl/instr_alu.sv
// Combinational ALU for one instruction word. Operands are sign-extended
// to the 64-bit result type before the operation; divide/modulo by zero
// and unknown opcodes return 0 with the matching error bit set.
module instr_alu
  import instr_register_pkg::*;
(
  input  instruction_t instr,
  output result_t      res,
  output logic [1:0]   err
);

  result_t a;
  result_t b;

  assign a = result_t'(instr.op_a);
  assign b = result_t'(instr.op_b);

  // Opcode decode and arithmetic.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    res = '0;
    err = '0;
    case (instr.opc)
      ZERO:  res = '0;
      PASSA: res = a;
      PASSB: res = b;
      ADD:   res = a + b;
      SUB:   res = a - b;
      MULT:  res = a * b;
      DIV: begin
        if (b == '0) err = ERR_DIV0;
        else         res = a / b;
      end
      MOD: begin
        if (b == '0) err = ERR_DIV0;
        else         res = a % b;
      end
      default: err = ERR_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/instr_exec_unit.sv
// Instruction execution unit. On start it walks read_pointer over a window
// of instr_register slots, executes each word and offers one result per
// instruction on a valid/ready port. Optional macro EXEC_STATS_EN adds
// saturating counters of accepted results and accepted errored results.
module instr_exec_unit
  import instr_register_pkg::*;
#(
  parameter int RES_WIDTH = 64,
  parameter int NUM_SLOTS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  address_t          first_addr,
  input  logic [5:0]        count,
  output address_t          read_pointer,
  input  instruction_t      instruction_word,
  output logic              busy,
  output logic              done,
  instr_exec_unit_if.master res_if
`ifdef EXEC_STATS_EN
  ,
  output logic [15:0]       stat_ops,
  output logic [15:0]       stat_errs
`endif
);

  exec_state_t  state;
  instruction_t ir;
  logic [5:0]   remaining;
  result_t      alu_res;
  logic [1:0]   alu_err;
  logic         accept;

  assign accept = res_if.res_valid && res_if.res_ready;

  instr_alu u_alu (
    .instr (ir),
    .res   (alu_res),
    .err   (alu_err)
  );

  // Run sequencing, instruction capture and registered result port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      read_pointer      <= '0;
      remaining         <= '0;
      // NOTE: ir is a plain register, not a memory, so it is reset along with the rest of the state.
      ir                <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      res_if.res_valid  <= 1'b0;
      res_if.res_addr   <= '0;
      res_if.res_opcode <= ZERO;
      res_if.result     <= '0;
      res_if.res_err    <= '0;
    end else begin
      // NOTE: non-blocking updates so every register sees pre-edge values of the others.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              read_pointer <= first_addr;
              remaining    <= (count > 6'(MAX_COUNT)) ? 6'(MAX_COUNT) : count;
              busy         <= 1'b1;
              state        <= FETCH;
            end
          end
        end
        FETCH: begin
          ir    <= instruction_word;
          state <= EXEC;
        end
        EXEC: begin
          res_if.result     <= RES_WIDTH'(alu_res);
          res_if.res_err    <= alu_err;
          res_if.res_addr   <= read_pointer;
          res_if.res_opcode <= ir.opc;
          res_if.res_valid  <= 1'b1;
          state             <= HOLD;
        end
        HOLD: begin
          if (accept) begin
            res_if.res_valid <= 1'b0;
            remaining        <= remaining - 6'd1;
            if (remaining == 6'd1) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              read_pointer <= (read_pointer == address_t'(NUM_SLOTS - 1)) ? '0
                                                                         : read_pointer + 1'b1;
              state        <= FETCH;
            end
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EXEC_STATS_EN
  // Saturating counters of accepted results and accepted errored results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_ops  <= '0;
      stat_errs <= '0;
    end else if (accept) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (res_if.res_err != '0 && stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_exec_unit.sv
// Randomized scoreboard bench for instr_exec_unit: directed runs from the
// test plan plus random windows, random back-pressure and reset mid-run.
`timescale 1ns/1ps
module tb_instr_exec_unit;
  import instr_register_pkg::*;

  typedef struct {
    address_t   addr;
    opcode_t    opc;
    longint     res;
    logic [1:0] err;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  address_t     first_addr;
  logic [5:0]   count;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         busy;
  logic         done;
`ifdef EXEC_STATS_EN
  logic [15:0]  stat_ops;
  logic [15:0]  stat_errs;
  int           model_ops  = 0;
  int           model_errs = 0;
`endif

  instruction_t mem [32];
  exp_t         sb [$];
  int           total    = 0;
  int           bad      = 0;
  int           done_cnt = 0;

  always #5 clk = ~clk;

  // Instruction register stand-in: combinational read.
  assign instruction_word = mem[read_pointer];

  instr_exec_unit_if #(.RES_WIDTH(64)) rif ();

  instr_exec_unit #(.RES_WIDTH(64), .NUM_SLOTS(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .first_addr       (first_addr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .busy             (busy),
    .done             (done),
    .res_if           (rif)
`ifdef EXEC_STATS_EN
    ,
    .stat_ops         (stat_ops),
    .stat_errs        (stat_errs)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: what the slot's instruction must produce, from plain arithmetic.
  function automatic exp_t model(input address_t a);
    instruction_t w;
    longint       x;
    longint       y;
    exp_t         e;
    w     = mem[a];
    x     = longint'(w.op_a);
    y     = longint'(w.op_b);
    e.addr = a;
    e.opc  = w.opc;
    e.res  = 0;
    e.err  = 2'b00;
    case (w.opc)
      ZERO:  e.res = 0;
      PASSA: e.res = x;
      PASSB: e.res = y;
      ADD:   e.res = x + y;
      SUB:   e.res = x - y;
      MULT:  e.res = x * y;
      DIV:   if (y == 0) e.err = 2'b01; else e.res = x / y;
      MOD:   if (y == 0) e.err = 2'b01; else e.res = x % y;
      default: e.err = 2'b10;
    endcase
    return e;
  endfunction

  function automatic instruction_t rand_instr();
    instruction_t w;
    w.opc  = opcode_t'($urandom_range(0, 15));
    w.op_a = ($urandom_range(0, 1) == 0) ? operand_t'($urandom)
                                         : operand_t'($urandom_range(0, 200)) - 100;
    w.op_b = ($urandom_range(0, 5) == 0) ? operand_t'(0)
                                         : operand_t'($urandom);
    return w;
  endfunction

  function automatic instruction_t mk(input opcode_t o, input int a, input int b);
    instruction_t w;
    w.opc  = o;
    w.op_a = operand_t'(a);
    w.op_b = operand_t'(b);
    return w;
  endfunction

  // Monitor: compares each accepted result with the scoreboard head and
  // checks the payload stays frozen while the consumer stalls.
  logic       held = 1'b0;
  logic [63:0] h_res;
  address_t   h_addr;
  address_t   h_rp;
  logic [1:0] h_err;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done) done_cnt++;
    if (reset || !rif.res_valid) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_result", rif.result, h_res);
        check("hold_addr", 64'(rif.res_addr), 64'(h_addr));
        check("hold_err", 64'(rif.res_err), 64'(h_err));
        check("hold_read_pointer", 64'(read_pointer), 64'(h_rp));
      end
      if (rif.res_ready) begin
        held = 1'b0;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got addr %0d with nothing expected", rif.res_addr);
        end else begin
          e = sb.pop_front();
          check("res_addr", 64'(rif.res_addr), 64'(e.addr));
          check("res_opcode", 64'(rif.res_opcode), 64'(e.opc));
          check("result", rif.result, e.res);
          check("res_err", 64'(rif.res_err), 64'(e.err));
`ifdef EXEC_STATS_EN
          model_ops++;
          if (e.err != 2'b00) model_errs++;
`endif
        end
      end else begin
        held   = 1'b1;
        h_res  = rif.result;
        h_addr = rif.res_addr;
        h_err  = rif.res_err;
        h_rp   = read_pointer;
      end
    end
  end

  // One run; mode 0: ready high, 1: random ready, 2: stall 5 cycles per result.
  task automatic run(input address_t fa, input int cnt, input int mode, input int want_lat);
    int n;
    int cyc;
    int first;
    int vcnt;
    int d0;
    bit fin;
    n = (cnt > 32) ? 32 : cnt;
    for (int i = 0; i < n; i++) sb.push_back(model(address_t'(fa + i)));
    d0 = done_cnt; cyc = 0; first = 0; vcnt = 0; fin = 1'b0;
    @(posedge clk); #1;
    first_addr    = fa;
    count         = 6'(cnt);
    start         = 1'b1;
    rif.res_ready = (mode != 2);
    while (!fin && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      start      = 1'b0;
      first_addr = address_t'($urandom);
      count      = 6'($urandom);
      if (cyc == 1) check("busy_running", 64'(busy), 64'(n > 0));
      if (first == 0 && (rif.res_valid || done)) first = cyc;
      if (done) fin = 1'b1;
      else if (busy && $urandom_range(0, 7) == 0) start = 1'b1;
      vcnt = rif.res_valid ? vcnt + 1 : 0;
      case (mode)
        0:       rif.res_ready = 1'b1;
        1:       rif.res_ready = 1'($urandom_range(0, 1));
        default: rif.res_ready = (vcnt > 5);
      endcase
    end
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL run_timeout: no done after %0d cycles (first_addr %0d count %0d)", cyc, fa, cnt);
    end else begin
      if (want_lat > 0) check("first_latency", 64'(first), 64'(want_lat));
      check("busy_at_done", 64'(busy), 64'(0));
      check("results_consumed", 64'(sb.size()), 64'(0));
      @(posedge clk); #1;
      check("done_width", 64'(done), 64'(0));
      check("done_pulses", 64'(done_cnt - d0), 64'(1));
    end
    sb.delete();
    start         = 1'b0;
    rif.res_ready = 1'b1;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0;
    int cyc;
    reset         = 1'b1;
    start         = 1'b0;
    first_addr    = '0;
    count         = '0;
    rif.res_ready = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = rand_instr();

    repeat (3) @(posedge clk);
    #1;
    check("rst_read_pointer", 64'(read_pointer), 64'(0));
    check("rst_res_valid", 64'(rif.res_valid), 64'(0));
    check("rst_result", rif.result, 64'(0));
    check("rst_res_err", 64'(rif.res_err), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    reset = 1'b0;

    // Single ADD: first valid 3 cycles after start, done one cycle later.
    mem[0] = mk(ADD, 5, -3);
    run(5'd0, 1, 0, 3);

    // Window wrapping past slot 31.
    mem[30] = mk(MULT, 40000, 40000);
    mem[31] = mk(SUB, -7, 9);
    mem[0]  = mk(PASSB, 0, 11);
    run(5'd30, 3, 0, 3);

    // Divide by zero, then signed modulo.
    mem[3] = mk(DIV, 7, 0);
    mem[4] = mk(MOD, -7, 2);
    run(5'd3, 2, 0, 3);

    // Back-pressure: 5 stalled cycles per result.
    mem[5] = mk(ADD, 100, 23);
    mem[6] = mk(opcode_t'(4'd12), 1, 2);
    run(5'd5, 2, 2, 3);

    // Empty run: done one cycle after start.
    run(5'd9, 0, 0, 1);

    // Random windows, including counts that saturate at 32.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 32; i++) mem[i] = rand_instr();
      run(address_t'($urandom), int'($urandom_range(0, 40)), 1, 0);
    end
    run(address_t'($urandom), 40, 1, 0);

    // Reset during HOLD of a 4-instruction run.
    for (int i = 0; i < 32; i++) mem[i] = rand_instr();
    rif.res_ready = 1'b0;
    @(posedge clk); #1;
    first_addr = 5'd10;
    count      = 6'd4;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 0;
    while (!rif.res_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("hold_reached", 64'(rif.res_valid), 64'(1));
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_read_pointer", 64'(read_pointer), 64'(0));
    check("midrst_res_valid", 64'(rif.res_valid), 64'(0));
    check("midrst_result", rif.result, 64'(0));
    check("midrst_res_addr", 64'(rif.res_addr), 64'(0));
    check("midrst_res_err", 64'(rif.res_err), 64'(0));
    check("midrst_res_opcode", 64'(rif.res_opcode), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
`ifdef EXEC_STATS_EN
    check("midrst_stat_ops", 64'(stat_ops), 64'(0));
    model_ops  = 0;
    model_errs = 0;
`endif
    sb.delete();
    @(posedge clk); #1;
    reset         = 1'b0;
    rif.res_ready = 1'b1;
    d0            = done_cnt;
    repeat (5) @(posedge clk);
    #1;
    check("no_done_after_reset", 64'(done_cnt - d0), 64'(0));
    check("idle_after_reset", 64'(busy), 64'(0));
    run(5'd20, 3, 0, 3);

`ifdef EXEC_STATS_EN
    check("stat_ops", 64'(stat_ops), 64'(model_ops));
    check("stat_errs", 64'(stat_errs), 64'(model_errs));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
